// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes, denomination values, FSM states and pricing.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } vend_state_t;

  // Value of a coin code in Rs5 units.
  function automatic logic [2:0] coin_val(input logic [1:0] code);
    case (code)
      COIN_5:  return 3'd1;
      COIN_10: return 3'd2;
      COIN_20: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic int price(input int idx, input int base, input int step);
    return base + idx * step;
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// Greedy change selector: largest coin not exceeding the given credit (none at zero).
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 5
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [1:0]          o_coin,
  output logic [2:0]          o_val
);

  always_comb begin
    o_coin = COIN_NONE;
    if (i_credit >= CREDIT_W'(4))      o_coin = COIN_20;
    else if (i_credit >= CREDIT_W'(2)) o_coin = COIN_10;
    else if (i_credit != '0)           o_coin = COIN_5;
    o_val = coin_val(o_coin);
  end

endmodule

// File: rtl/vend_multi_change.sv
// Multi-product vending FSM with greedy change return over a valid/ack handshake.
// Optional per-product stock tracking and sold_out output when VEND_STOCK_EN is defined.
module vend_multi_change
  import vend_pkg::*;
#(
  parameter int NUM_PROD   = 4,
  parameter int PRICE_BASE = 3,
  parameter int PRICE_STEP = 1,
  parameter int CREDIT_W   = 5,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 15,
  localparam int SEL_W     = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  input  logic                change_ack,
  output logic                out_bottle,
  output logic [SEL_W-1:0]    out_prod,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic                coin_reject,
  output logic                sel_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
`ifdef VEND_STOCK_EN
  ,
  output logic [NUM_PROD-1:0] sold_out
`endif
);

  localparam logic [CREDIT_W:0] CREDIT_MAX_W = {1'b0, {CREDIT_W{1'b1}}};

  if ((PRICE_BASE + (NUM_PROD - 1) * PRICE_STEP > 2**CREDIT_W - 1) ||
      (STOCK_INIT > 2**STOCK_W - 1)) begin : g_param_check
    $error("vend_multi_change: top price exceeds credit range or STOCK_INIT exceeds STOCK_W");
  end

  vend_state_t         r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic                r_out_bottle, w_bottle_nxt;
  logic [SEL_W-1:0]    r_out_prod, w_prod_nxt;
  logic                r_coin_reject, w_coin_rej_nxt;
  logic                r_sel_reject, w_sel_rej_nxt;
  logic                r_change_valid;
  logic [1:0]          r_change_coin;
  logic [2:0]          r_change_val;
  logic                r_busy;

  logic [CREDIT_W:0]   w_price;
  logic [CREDIT_W:0]   w_coin_sum;
  logic                w_coin_live;
  logic                w_sel_in_range;
  logic                w_stock_ok;
  logic                w_sel_ok;
  logic                w_vend;
  logic [1:0]          w_greedy_coin;
  logic [2:0]          w_greedy_val;
  logic                w_change_nxt;

  assign w_price        = (CREDIT_W+1)'(price(int'(sel), PRICE_BASE, PRICE_STEP));
  assign w_coin_sum     = {1'b0, r_credit} + (CREDIT_W+1)'(coin_val(coin));
  assign w_coin_live    = coin_valid && (coin != COIN_NONE);
  assign w_sel_in_range = ({1'b0, sel} < (SEL_W+1)'(NUM_PROD));
  assign w_sel_ok       = w_sel_in_range && ({1'b0, r_credit} >= w_price) && w_stock_ok;

`ifdef VEND_STOCK_EN
  logic [STOCK_W-1:0]  r_stock [NUM_PROD];
  logic [STOCK_W-1:0]  w_stock_nxt [NUM_PROD];
  logic [NUM_PROD-1:0] r_sold_out;

  always_comb begin
    w_stock_ok = 1'b0;
    for (int i = 0; i < NUM_PROD; i++) begin
      w_stock_nxt[i] = r_stock[i];
      if (sel == SEL_W'(i) && r_stock[i] != '0) w_stock_ok = 1'b1;
      if (w_vend && sel == SEL_W'(i)) w_stock_nxt[i] = r_stock[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PROD; i++) r_stock[i] <= STOCK_W'(STOCK_INIT);
      r_sold_out <= {NUM_PROD{STOCK_INIT == 0}};
    end else begin
      for (int i = 0; i < NUM_PROD; i++) begin
        r_stock[i]    <= w_stock_nxt[i];
        r_sold_out[i] <= (w_stock_nxt[i] == '0);
      end
    end
  end

  assign sold_out = r_sold_out;
`else
  assign w_stock_ok = 1'b1;
`endif

  vend_change_sel #(.CREDIT_W(CREDIT_W)) u_change_sel (
    .i_credit (w_credit_nxt),
    .o_coin   (w_greedy_coin),
    .o_val    (w_greedy_val)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_bottle_nxt   = 1'b0;
    w_prod_nxt     = '0;
    w_coin_rej_nxt = 1'b0;
    w_sel_rej_nxt  = 1'b0;
    w_vend         = 1'b0;
    case (r_state)
      IDLE, CREDIT: begin
        // cancel only takes the cycle when there is credit to refund
        if (cancel && r_state == CREDIT) begin
          w_state_nxt    = CHANGE;
          w_coin_rej_nxt = w_coin_live;
        end else if (sel_valid) begin
          w_coin_rej_nxt = w_coin_live;
          if (w_sel_ok) begin
            w_state_nxt  = VEND;
            w_credit_nxt = r_credit - w_price[CREDIT_W-1:0];
            w_bottle_nxt = 1'b1;
            w_prod_nxt   = sel;
            w_vend       = 1'b1;
          end else begin
            w_sel_rej_nxt = 1'b1;
          end
        end else if (w_coin_live) begin
          if (w_coin_sum > CREDIT_MAX_W) begin
            w_coin_rej_nxt = 1'b1;
          end else begin
            w_credit_nxt = w_coin_sum[CREDIT_W-1:0];
            w_state_nxt  = CREDIT;
          end
        end
      end
      VEND: begin
        w_coin_rej_nxt = w_coin_live;
        w_state_nxt    = (r_credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        w_coin_rej_nxt = w_coin_live;
        if (change_ack) begin
          w_credit_nxt = r_credit - CREDIT_W'(r_change_val);
          if (r_credit == CREDIT_W'(r_change_val)) w_state_nxt = IDLE;
        end
      end
    endcase
  end

  assign w_change_nxt = (w_state_nxt == CHANGE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_credit       <= '0;
      r_out_bottle   <= 1'b0;
      r_out_prod     <= '0;
      r_coin_reject  <= 1'b0;
      r_sel_reject   <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_coin  <= COIN_NONE;
      r_change_val   <= '0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_out_bottle   <= w_bottle_nxt;
      r_out_prod     <= w_prod_nxt;
      r_coin_reject  <= w_coin_rej_nxt;
      r_sel_reject   <= w_sel_rej_nxt;
      r_change_valid <= w_change_nxt;
      r_change_coin  <= w_change_nxt ? w_greedy_coin : COIN_NONE;
      r_change_val   <= w_change_nxt ? w_greedy_val : 3'd0;
      r_busy         <= (w_state_nxt == VEND) || w_change_nxt;
    end
  end

  assign out_bottle   = r_out_bottle;
  assign out_prod     = r_out_prod;
  assign change_valid = r_change_valid;
  assign change_coin  = r_change_coin;
  assign coin_reject  = r_coin_reject;
  assign sel_reject   = r_sel_reject;
  assign credit       = r_credit;
  assign busy         = r_busy;

endmodule

// File: tb/tb_vend_multi_change.sv
// Testbench for vend_multi_change: directed vector table, reset corner case, randomized run vs. model.
module tb_vend_multi_change;

  localparam int NP  = 3;
  localparam int PB  = 3;
  localparam int PS  = 1;
  localparam int CW  = 5;
  localparam int SW  = 2;
  localparam int STW = 4;
  localparam int SI  = 15;
  localparam int CMAX = 2**CW - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          coin_valid, sel_valid, cancel, change_ack;
  logic [1:0]    coin;
  logic [SW-1:0] sel;
  logic          out_bottle, change_valid, coin_reject, sel_reject, busy;
  logic [SW-1:0] out_prod;
  logic [1:0]    change_coin;
  logic [CW-1:0] credit;
`ifdef VEND_STOCK_EN
  logic [NP-1:0] sold_out;
`endif

  int checks = 0;
  int errors = 0;

  vend_multi_change #(
    .NUM_PROD(NP), .PRICE_BASE(PB), .PRICE_STEP(PS),
    .CREDIT_W(CW), .STOCK_W(STW), .STOCK_INIT(SI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin(coin),
    .sel_valid(sel_valid), .sel(sel),
    .cancel(cancel), .change_ack(change_ack),
    .out_bottle(out_bottle), .out_prod(out_prod),
    .change_valid(change_valid), .change_coin(change_coin),
    .coin_reject(coin_reject), .sel_reject(sel_reject),
    .credit(credit), .busy(busy)
`ifdef VEND_STOCK_EN
    , .sold_out(sold_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic cv; logic [1:0] coin; logic sv; logic [1:0] sel; logic can; logic ack;
    int credit; logic bottle; logic [1:0] prod; logic chv; logic [1:0] chc;
    logic crej; logic srej; logic busy;
  } vec_t;
  vec_t tbl[$];

  // Reference model: abstract phase (0 accepting, 1 vending, 2 returning change)
  int   m_credit, m_phase;
  int   m_stock[NP];
  logic m_bottle, m_crej, m_srej;
  int   m_prod;

  function automatic int greedy_val(int c);
    if (c >= 4) return 4;
    if (c >= 2) return 2;
    if (c >= 1) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] val_code(int v);
    case (v)
      4: return 2'b11;
      2: return 2'b10;
      1: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic int cval(logic [1:0] c);
    return (c == 2'b11) ? 4 : int'(c);
  endfunction

  task automatic model_reset();
    m_credit = 0; m_phase = 0; m_bottle = 0; m_crej = 0; m_srej = 0; m_prod = 0;
    for (int i = 0; i < NP; i++) m_stock[i] = SI;
  endtask

  task automatic model_step();
    bit live;
    int p;
    bit stock_ok;
    live = coin_valid && (coin != 2'b00);
    m_bottle = 0; m_crej = 0; m_srej = 0;
    case (m_phase)
      0: begin
        if (cancel && m_credit > 0) begin
          m_phase = 2; m_crej = live;
        end else if (sel_valid) begin
          m_crej = live;
          p = PB + int'(sel) * PS;
          stock_ok = 1;
`ifdef VEND_STOCK_EN
          stock_ok = (int'(sel) < NP) && (m_stock[int'(sel) % NP] > 0);
`endif
          if (int'(sel) < NP && m_credit >= p && stock_ok) begin
            m_credit -= p; m_bottle = 1; m_prod = int'(sel); m_phase = 1;
            m_stock[int'(sel)] -= 1;
          end else begin
            m_srej = 1;
          end
        end else if (live) begin
          if (m_credit + cval(coin) > CMAX) m_crej = 1;
          else m_credit += cval(coin);
        end
      end
      1: begin
        m_crej = live;
        m_phase = (m_credit > 0) ? 2 : 0;
      end
      default: begin
        m_crej = live;
        if (change_ack) begin
          m_credit -= greedy_val(m_credit);
          if (m_credit == 0) m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic cv, input logic [1:0] c, input logic sv,
                        input logic [1:0] s, input logic can, input logic ack);
    coin_valid = cv; coin = c; sel_valid = sv; sel = s; cancel = can; change_ack = ack;
  endtask

  task automatic add(input logic cv, input logic [1:0] c, input logic sv, input logic [1:0] s,
                     input logic can, input logic ack, input int cr, input logic bot,
                     input logic [1:0] prod, input logic chv, input logic [1:0] chc,
                     input logic crej, input logic srej, input logic bsy);
    vec_t v;
    v.cv = cv; v.coin = c; v.sv = sv; v.sel = s; v.can = can; v.ack = ack;
    v.credit = cr; v.bottle = bot; v.prod = prod; v.chv = chv; v.chc = chc;
    v.crej = crej; v.srej = srej; v.busy = bsy;
    tbl.push_back(v);
  endtask

  task automatic check_model(input string tag);
    chk({tag, " credit"}, 32'(credit), 32'(m_credit));
    chk({tag, " bottle"}, 32'(out_bottle), 32'(m_bottle));
    if (m_bottle) chk({tag, " prod"}, 32'(out_prod), 32'(m_prod));
    chk({tag, " chg_valid"}, 32'(change_valid), 32'(m_phase == 2));
    chk({tag, " chg_coin"}, 32'(change_coin),
        32'((m_phase == 2) ? val_code(greedy_val(m_credit)) : 2'b00));
    chk({tag, " coin_rej"}, 32'(coin_reject), 32'(m_crej));
    chk({tag, " sel_rej"}, 32'(sel_reject), 32'(m_srej));
    chk({tag, " busy"}, 32'(busy), 32'(m_phase != 0));
`ifdef VEND_STOCK_EN
    for (int i = 0; i < NP; i++) chk({tag, " sold_out"}, 32'(sold_out[i]), 32'(m_stock[i] == 0));
`endif
  endtask

  initial begin
    set_in(0, 2'b00, 0, 2'b00, 0, 0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("reset credit", 32'(credit), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset chg_valid", 32'(change_valid), 0);
    chk("reset bottle", 32'(out_bottle), 0);
    rst_n = 1'b1;

    // cv coin sv sel can ack | credit bot prod chv chc crej srej busy
    add(1, 2'b01, 0, 0, 0, 0,  1, 0, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b10, 0, 0, 0, 0,  3, 0, 0, 0, 2'b00, 0, 0, 0);
    add(0, 2'b00, 1, 0, 0, 0,  0, 1, 0, 0, 2'b00, 0, 0, 1);
    add(0, 2'b00, 0, 0, 0, 0,  0, 0, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b11, 0, 0, 0, 0,  4, 0, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b11, 0, 0, 0, 0,  8, 0, 0, 0, 2'b00, 0, 0, 0);
    add(0, 2'b00, 1, 2, 0, 0,  3, 1, 2, 0, 2'b00, 0, 0, 1);
    add(0, 2'b00, 0, 0, 0, 0,  3, 0, 0, 1, 2'b10, 0, 0, 1);
    add(0, 2'b00, 0, 0, 0, 0,  3, 0, 0, 1, 2'b10, 0, 0, 1);
    add(0, 2'b00, 0, 0, 0, 0,  3, 0, 0, 1, 2'b10, 0, 0, 1);
    add(0, 2'b00, 0, 0, 0, 1,  1, 0, 0, 1, 2'b01, 0, 0, 1);
    add(0, 2'b00, 0, 0, 0, 1,  0, 0, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b10, 0, 0, 0, 0,  2, 0, 0, 0, 2'b00, 0, 0, 0);
    add(0, 2'b00, 1, 1, 0, 0,  2, 0, 0, 0, 2'b00, 0, 1, 0);
    add(0, 2'b00, 0, 0, 1, 0,  2, 0, 0, 1, 2'b10, 0, 0, 1);
    add(0, 2'b00, 0, 0, 0, 1,  0, 0, 0, 0, 2'b00, 0, 0, 0);
    for (int k = 1; k <= 7; k++) add(1, 2'b11, 0, 0, 0, 0, 4 * k, 0, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b10, 0, 0, 0, 0, 30, 0, 0, 0, 2'b00, 0, 0, 0);
    add(1, 2'b11, 0, 0, 0, 0, 30, 0, 0, 0, 2'b00, 1, 0, 0);
    add(0, 2'b00, 1, 3, 0, 0, 30, 0, 0, 0, 2'b00, 0, 1, 0);
    add(1, 2'b01, 1, 2, 0, 0, 25, 1, 2, 0, 2'b00, 1, 0, 1);
    add(0, 2'b00, 0, 0, 0, 0, 25, 0, 0, 1, 2'b11, 0, 0, 1);
    add(1, 2'b11, 0, 0, 0, 1, 21, 0, 0, 1, 2'b11, 1, 0, 1);
    add(0, 2'b00, 0, 0, 0, 1, 17, 0, 0, 1, 2'b11, 0, 0, 1);
    add(0, 2'b00, 0, 0, 0, 1, 13, 0, 0, 1, 2'b11, 0, 0, 1);
    add(0, 2'b00, 0, 0, 0, 1,  9, 0, 0, 1, 2'b11, 0, 0, 1);
    add(0, 2'b00, 0, 0, 0, 1,  5, 0, 0, 1, 2'b11, 0, 0, 1);
    add(0, 2'b00, 0, 0, 0, 1,  1, 0, 0, 1, 2'b01, 0, 0, 1);
    add(0, 2'b00, 0, 0, 0, 1,  0, 0, 0, 0, 2'b00, 0, 0, 0);

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      set_in(tbl[i].cv, tbl[i].coin, tbl[i].sv, tbl[i].sel, tbl[i].can, tbl[i].ack);
      tick();
      chk({tag, " credit"}, 32'(credit), 32'(tbl[i].credit));
      chk({tag, " bottle"}, 32'(out_bottle), 32'(tbl[i].bottle));
      if (tbl[i].bottle) chk({tag, " prod"}, 32'(out_prod), 32'(tbl[i].prod));
      chk({tag, " chg_valid"}, 32'(change_valid), 32'(tbl[i].chv));
      chk({tag, " chg_coin"}, 32'(change_coin), 32'(tbl[i].chc));
      chk({tag, " coin_rej"}, 32'(coin_reject), 32'(tbl[i].crej));
      chk({tag, " sel_rej"}, 32'(sel_reject), 32'(tbl[i].srej));
      chk({tag, " busy"}, 32'(busy), 32'(tbl[i].busy));
    end

    // Asynchronous reset in the middle of change return
    set_in(1, 2'b11, 0, 0, 0, 0); tick();
    set_in(1, 2'b01, 0, 0, 0, 0); tick();
    set_in(0, 2'b00, 0, 0, 1, 0); tick();
    set_in(0, 2'b00, 0, 0, 0, 0);
    chk("pre-rst chg_valid", 32'(change_valid), 1);
    chk("pre-rst credit", 32'(credit), 5);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async rst credit", 32'(credit), 0);
    chk("async rst chg_valid", 32'(change_valid), 0);
    chk("async rst chg_coin", 32'(change_coin), 0);
    chk("async rst busy", 32'(busy), 0);
    chk("async rst rejects", 32'({coin_reject, sel_reject, out_bottle}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 2'b01, 0, 0, 0, 0);
    tick();
    chk("post-rst credit", 32'(credit), 1);
    chk("post-rst busy", 32'(busy), 0);

    // Randomized traffic checked against the model every cycle
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
             $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)),
             $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)));
      tick();
      check_model($sformatf("rnd%0d", n));
    end

    set_in(0, 2'b00, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_multi_change.md
Name: vend_multi_change

Overview:
- Parametrised successor to the single-product vending FSM.
- Accumulates credit from coded coins and serves NUM_PROD products with per-product prices.
- Returns change as a greedy sequence of coins over a valid/ack handshake; supports cancel/refund.
- Sits between the coin acceptor front-end and the dispenser/change-hopper drivers.

Parameters:
- NUM_PROD, 4: number of products; SEL_W = max(1, clog2(NUM_PROD)).
- PRICE_BASE, 3: price of product 0, in Rs5 units.
- PRICE_STEP, 1: price(i) = PRICE_BASE + i*PRICE_STEP, in units.
- CREDIT_W, 5: credit register width; CREDIT_MAX = 2**CREDIT_W-1.
- STOCK_W, 4: stock counter width (VEND_STOCK_EN only).
- STOCK_INIT, 15: per-product stock value after reset (VEND_STOCK_EN only).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- coin_valid  in  1  coin strobe, one cycle per coin
- coin  in  2  00 none, 01 = 1 unit (Rs5), 10 = 2 units (Rs10), 11 = 4 units (Rs20)
- sel_valid  in  1  product request strobe
- sel  in  SEL_W  product index
- cancel  in  1  refund request
- change_ack  in  1  hopper has taken the presented change coin
- out_bottle  out  1  one-cycle vend pulse
- out_prod  out  SEL_W  product being vended; valid with out_bottle
- change_valid  out  1  change coin presented
- change_coin  out  2  coin code of the presented change coin
- coin_reject  out  1  one-cycle pulse: coin not accepted
- sel_reject  out  1  one-cycle pulse: selection refused
- credit  out  CREDIT_W  current credit, in units
- busy  out  1  high in VEND or CHANGE

Behaviour:
- Reset (async, rst_n = 0): state IDLE; credit 0; all outputs 0 immediately. Any credit held mid-operation is discarded. Release is synchronous to clk.
- All outputs are registered. Each request is sampled at edge N; its effect is visible in cycle N+1.
- States: IDLE (credit 0), CREDIT (credit > 0), VEND, CHANGE.
- Per-cycle priority in IDLE/CREDIT: cancel > sel_valid > coin_valid. A lower-priority coin in the same cycle is rejected (coin_reject); a lower-priority sel is ignored.
- Coin handling:
  - coin_valid with coin = 00 is ignored.
  - If credit + value > CREDIT_MAX: coin_reject, credit unchanged.
  - Otherwise credit += value and state becomes CREDIT.
- Selection handling (sel_valid):
  - sel >= NUM_PROD, or credit < price(sel): sel_reject; state and credit unchanged. Applies in IDLE too.
  - Otherwise go to VEND: out_bottle = 1 and out_prod = sel for exactly one cycle, credit -= price(sel).
  - From VEND: to CHANGE if the remaining credit > 0, else IDLE.
- cancel: in CREDIT goes to CHANGE with the full credit; in IDLE it is ignored.
- CHANGE state:
  - change_valid = 1.
  - change_coin = largest denomination <= credit (11 if credit >= 4, else 10 if >= 2, else 01).
  - On change_ack: credit -= value; the next coin is recomputed the following cycle.
  - When credit reaches 0: change_valid drops and state returns to IDLE.
  - change_coin and credit stay stable while change_valid && !change_ack.
  - change_ack outside CHANGE is ignored.
- Any coin_valid during VEND or CHANGE produces coin_reject. sel_valid and cancel are ignored there.
- Price arithmetic uses CREDIT_W+1 bits. Precondition (elaboration-time check): price(NUM_PROD-1) <= CREDIT_MAX.

Optional Feature:
- Macro VEND_STOCK_EN.
- Defined:
  - Per-product STOCK_W-bit counters, set to STOCK_INIT on reset.
  - A counter decrements on each vend of its product.
  - sel of a product with stock 0 gives sel_reject.
  - Extra output sold_out [NUM_PROD-1:0], registered; bit i = (stock[i] == 0).
- Undefined: stock is unlimited; no counters; no sold_out port.

Decomposition:
- Package vend_pkg holds:
  - coin code constants (COIN_NONE/5/10/20);
  - denomination value function coin_val();
  - state enum vend_state_t (IDLE, CREDIT, VEND, CHANGE);
  - price(i) function.
- Sub-module vend_change_sel: combinational greedy selector. Inputs: credit. Outputs: change_coin code and value. Instantiated once by the top-level FSM.

Test Plan:
- Coins 01, 10 (credit 3); sel = 0 -> out_bottle pulse with out_prod = 0; credit 0; IDLE; change_valid never asserted.
- Coins 11, 11 (credit 8); sel = 2 (price 5) -> vend; then change 10 then 01; change_ack held low 2 cycles on the first coin -> change_coin stays 10 and credit stays 3.
- Credit 2; sel = 1 (price 4) -> sel_reject, credit stays 2; cancel -> one change coin 10, then IDLE.
- Credit 30; coin 11 -> coin_reject, credit 30; sel = 3 with NUM_PROD = 3 -> sel_reject; coin + sel in the same cycle -> sel serviced, coin_reject.
- rst_n low mid-CHANGE (credit 5) -> all outputs 0 immediately, credit 0; after release, first coin 01 gives credit 1.
- VEND_STOCK_EN, STOCK_INIT = 1: vend product 0 -> sold_out[0] = 1; second sel = 0 with credit 3 -> sel_reject, credit kept.
